// File: rtl/quad_decoder.sv
// Quadrature decoder: two-flop synchronisers, per-channel stability filters and
// Gray-code step decode driving a wrap-around position counter.
module quad_decoder #(
  parameter int Width        = 16,
  parameter int FilterCycles = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             clear_i,
  output logic             up_o,
  output logic             down_o,
  output logic             err_o,
  output logic             dir_o,
  output logic [Width-1:0] position_o
);

  localparam int CntW       = $clog2(FilterCycles + 1);
  localparam int InitCycles = FilterCycles + 2;
  localparam int InitW      = $clog2(InitCycles + 1);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  // Returns {next_filtered, next_count}; acceptance happens on the FilterCycles-th differing sample.
  function automatic logic [CntW:0] filter_step(input logic synced, input logic filt,
                                                input logic [CntW-1:0] cnt);
    logic [CntW:0] res;
    if (synced == filt) begin
      res = {filt, {CntW{1'b0}}};
    end else if (cnt == CntW'(FilterCycles - 1)) begin
      res = {synced, {CntW{1'b0}}};
    end else begin
      res = {filt, cnt + CntW'(1)};
    end
    return res;
  endfunction

  // Maps {A,B} onto its position in the forward cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b10:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      2'b01:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  logic [1:0]       sync_a_q, sync_b_q;
  logic             a_s, b_s;
  logic             filt_a_q, filt_a_d, filt_b_q, filt_b_d;
  logic [CntW-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  state_e           state_q;
  logic [InitW-1:0] init_cnt_q;
  logic [1:0]       prev_q;
  logic [1:0]       delta_s;
  logic             seed_s, step_up_s, step_down_s, step_err_s;
  logic             up_q, down_q, err_q, dir_q;
  logic [Width-1:0] pos_q, pos_d;

  assign a_s     = sync_a_q[1];
  assign b_s     = sync_b_q[1];
  assign seed_s  = (state_q == INIT) && (init_cnt_q == InitW'(InitCycles - 1));
  assign delta_s = gray_idx({filt_a_q, filt_b_q}) - gray_idx(prev_q);

  assign step_up_s   = (state_q == RUN) && (delta_s == 2'b01);
  assign step_down_s = (state_q == RUN) && (delta_s == 2'b11);
  assign step_err_s  = (state_q == RUN) && (delta_s == 2'b10);

  // Filter next state; held idle during INIT and seeded straight from the synchronisers on exit.
  always_comb begin
    {filt_a_d, cnt_a_d} = filter_step(a_s, filt_a_q, cnt_a_q);
    {filt_b_d, cnt_b_d} = filter_step(b_s, filt_b_q, cnt_b_q);
    if (seed_s) begin
      filt_a_d = a_s;
      filt_b_d = b_s;
      cnt_a_d  = '0;
      cnt_b_d  = '0;
    end else if (state_q == INIT) begin
      filt_a_d = filt_a_q;
      filt_b_d = filt_b_q;
      cnt_a_d  = '0;
      cnt_b_d  = '0;
    end else begin
      filt_a_d = filt_a_d;
      filt_b_d = filt_b_d;
    end
  end

  // Position next state: clear wins over a coincident step.
  always_comb begin
    pos_d = pos_q;
    if (clear_i) begin
      pos_d = '0;
    end else if (step_up_s) begin
      pos_d = pos_q + Width'(1);
    end else if (step_down_s) begin
      pos_d = pos_q - Width'(1);
    end else begin
      pos_d = pos_q;
    end
  end

  // Synchroniser and filter registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_a_q <= 2'b00;
      sync_b_q <= 2'b00;
      filt_a_q <= 1'b0;
      filt_b_q <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
    end else begin
      sync_a_q <= {sync_a_q[0], a_i};
      sync_b_q <= {sync_b_q[0], b_i};
      filt_a_q <= filt_a_d;
      filt_b_q <= filt_b_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
    end
  end

  // Control FSM with registered pulses, direction and position.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      prev_q     <= 2'b00;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      err_q      <= 1'b0;
      dir_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      up_q   <= step_up_s;
      down_q <= step_down_s;
      err_q  <= step_err_s;
      pos_q  <= pos_d;
      if (step_up_s) begin
        dir_q <= 1'b1;
      end else if (step_down_s) begin
        dir_q <= 1'b0;
      end
      case (state_q)
        INIT: begin
          if (seed_s) begin
            prev_q  <= {a_s, b_s};
            state_q <= RUN;
          end else begin
            init_cnt_q <= init_cnt_q + InitW'(1);
          end
        end
        RUN: begin
          prev_q <= {filt_a_q, filt_b_q};
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  assign up_o       = up_q;
  assign down_o     = down_q;
  assign err_o      = err_q;
  assign dir_o      = dir_q;
  assign position_o = pos_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: a pin-history reference model checked every cycle,
// directed scenarios with literal expectations, then randomized pin activity.
module tb_quad_decoder;
  localparam int W  = 16;
  localparam int FC = 4;
  localparam int N  = FC + 2;

  logic         clk = 1'b0;
  logic         rstn_i = 1'b0, a_i = 1'b0, b_i = 1'b0, clear_i = 1'b0;
  logic         up_o, down_o, err_o, dir_o;
  logic [W-1:0] position_o;

  int total = 0, bad = 0, cyc = 0;
  int up_cnt = 0, down_cnt = 0, err_cnt = 0, first_up_cyc = -1, drv_cyc = 0;

  int       n;
  bit       qa[$], qb[$];
  bit [1:0] mf, mprev;
  bit       exp_up, exp_down, exp_err, exp_dir;
  int       exp_pos;
  int       gidx[4] = '{0, 3, 1, 2};
  bit [1:0] fseq[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quad_decoder #(.Width(W), .FilterCycles(FC)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .a_i(a_i), .b_i(b_i), .clear_i(clear_i),
    .up_o(up_o), .down_o(down_o), .err_o(err_o), .dir_o(dir_o), .position_o(position_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    n = 0;
    qa.delete();
    qb.delete();
    repeat (FC + 2) begin
      qa.push_back(1'b0);
      qb.push_back(1'b0);
    end
    mf = 2'b00; mprev = 2'b00;
    exp_up = 0; exp_down = 0; exp_err = 0; exp_dir = 0; exp_pos = 0;
  endtask

  // Pin p(n) sampled at edge n reaches the filter two edges later; a level is
  // accepted once the last FC synced samples all agree.
  task automatic model_step();
    int d;
    bit wa, wb;
    n++;
    qa.push_back(a_i); void'(qa.pop_front());
    qb.push_back(b_i); void'(qb.pop_front());
    exp_up = 0; exp_down = 0; exp_err = 0;
    if (n == N) begin
      mf = {qa[FC-1], qb[FC-1]};
      mprev = mf;
    end else if (n > N) begin
      d = (gidx[mf] - gidx[mprev] + 4) % 4;
      if (d == 1) begin exp_up = 1; exp_dir = 1; end
      else if (d == 3) begin exp_down = 1; exp_dir = 0; end
      else if (d == 2) exp_err = 1;
      mprev = mf;
      wa = 1; wb = 1;
      for (int i = 1; i < FC; i++) begin
        if (qa[i] != qa[0]) wa = 0;
        if (qb[i] != qb[0]) wb = 0;
      end
      if (wa) mf[1] = qa[0];
      if (wb) mf[0] = qb[0];
    end
    if (clear_i) exp_pos = 0;
    else if (exp_up) exp_pos = (exp_pos + 1) % (1 << W);
    else if (exp_down) exp_pos = (exp_pos + (1 << W) - 1) % (1 << W);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn_i);
      if (!rstn_i) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (rstn_i) begin
      check("up_o", up_o, exp_up);
      check("down_o", down_o, exp_down);
      check("err_o", err_o, exp_err);
      check("dir_o", dir_o, exp_dir);
      check("position_o", position_o, exp_pos);
      check("pulse_exclusive", (up_o + down_o + err_o) <= 1, 1);
      if (up_o) begin
        up_cnt++;
        if (first_up_cyc < 0) first_up_cyc = cyc;
      end
      if (down_o) down_cnt++;
      if (err_o) err_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic clr_counts();
    up_cnt = 0; down_cnt = 0; err_cnt = 0; first_up_cyc = -1;
  endtask

  task automatic drive(input bit a, input bit b, input int hold);
    a_i = a; b_i = b; drv_cyc = cyc;
    repeat (hold) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input bit a, input bit b);
    rstn_i = 1'b0; a_i = a; b_i = b; clear_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn_i = 1'b1;
    repeat (N + 6) @(posedge clk);
    #2 clr_counts();
  endtask

  initial begin
    bit [1:0] cur, g;
    int r, h, edge_cyc;

    #1;
    check("reset_pos", position_o, 0);
    check("reset_up", up_o, 0);

    do_reset(1, 1);
    repeat (20) @(posedge clk);
    #2;
    check("seed11_pulses", up_cnt + down_cnt + err_cnt, 0);
    check("seed11_pos", position_o, 0);

    do_reset(0, 0);
    drive(1, 0, 10);
    edge_cyc = cyc - 10;
    drive(1, 1, 10); drive(0, 1, 10); drive(0, 0, 10);
    check("fwd_latency", first_up_cyc - edge_cyc, 7);
    check("fwd_up_count", up_cnt, 4);
    check("fwd_pos", position_o, 4);
    check("fwd_dir", dir_o, 1);

    do_reset(0, 0);
    drive(0, 1, 10); drive(1, 1, 10); drive(1, 0, 10); drive(0, 0, 10);
    check("rev_down_count", down_cnt, 4);
    check("rev_pos", position_o, 16'hFFFC);
    check("rev_dir", dir_o, 0);

    do_reset(0, 0);
    drive(1, 0, 3); drive(0, 0, 12);
    check("glitch_pulses", up_cnt + down_cnt + err_cnt, 0);
    check("glitch_pos", position_o, 0);
    drive(1, 0, 10); drive(0, 1, 10);
    check("illegal_err", err_cnt, 1);
    check("illegal_pos", position_o, 1);
    check("illegal_dir", dir_o, 1);

    do_reset(0, 0);
    drive(0, 1, 10);
    check("wrap_down", position_o, 16'hFFFF);
    drive(0, 0, 10);
    check("wrap_up", position_o, 0);

    drive(1, 0, 10);
    a_i = 1'b1; b_i = 1'b1;
    repeat (6) @(posedge clk);
    #2 clear_i = 1'b1;
    @(posedge clk);
    #2 clear_i = 1'b0;
    check("clear_up_pulse", up_o, 1);
    check("clear_pos", position_o, 0);
    repeat (3) @(posedge clk);
    #2;

    do_reset(0, 0);
    for (int k = 0; k < 18; k++) begin
      cur = fseq[(k + 1) % 4];
      drive(cur[1], cur[0], 8);
    end
    check("pre_reset_pos", position_o, 18);
    #1 rstn_i = 1'b0;
    #1;
    check("async_rst_pos", position_o, 0);
    check("async_rst_dir", dir_o, 0);
    check("async_rst_pulses", up_o + down_o + err_o, 0);
    repeat (2) @(posedge clk);
    #2 rstn_i = 1'b1;
    repeat (N + 6) @(posedge clk);
    #2 drive(0, 1, 10);
    check("post_reset_step", position_o, 1);

    do_reset(0, 0);
    cur = 2'b00;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      h = $urandom_range(1, 12);
      clear_i = ($urandom_range(0, 7) == 0);
      if (r < 6) begin
        cur = fseq[(gidx[cur] + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4];
        drive(cur[1], cur[0], h);
      end else if (r < 8) begin
        g = cur ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
        drive(g[1], g[0], $urandom_range(1, FC));
        drive(cur[1], cur[0], h);
      end else begin
        cur = cur ^ 2'b11;
        drive(cur[1], cur[0], h);
      end
    end
    clear_i = 1'b0;
    drive(cur[1], cur[0], 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
